seg7_scan_driver: RTL

//   Parametrised multiplexed 7-segment driver for N digits; successor to the fixed 4-digit score display.

---
 rtl/seg7_scan_driver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver: hex decode, decimal points, leading-zero
// blanking, per-digit blank/blink, 16-level PWM brightness and frame-synchronous loading.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int          ACTIVE_LOW   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      lz_blank_en,
  input  logic [3:0]                brightness,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                sevenseg,
  output logic                      dp,
  output logic                      frame_done
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_FRAMES - 1);
  localparam logic          POL          = (ACTIVE_LOW != 0);

  logic [RW-1:0]             refresh_cnt_q, refresh_cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [3:0]                pwm_cnt_q, pwm_cnt_d;
  logic [BW-1:0]             blink_cnt_q, blink_cnt_d;
  logic                      blink_phase_q, blink_phase_d;
  logic [4*NUM_DIGITS-1:0]   pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0]   act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;

  logic                      slot_end, frame_end;
  logic [3:0]                cur_val;
  logic [6:0]                seg_hi;
  logic                      lz_dark, dark, lit;
  logic [NUM_DIGITS-1:0]     an_onehot;

  always_comb begin
    slot_end  = (refresh_cnt_q == REFRESH_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    refresh_cnt_d = slot_end ? '0 : refresh_cnt_q + 1'b1;
    idx_d         = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    pwm_cnt_d = pwm_cnt_q + 4'd1;

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Active copies the pre-load pending, so a coincident load lands one frame later.
    act_dig_d  = frame_end ? pend_dig_q : act_dig_q;
    act_dp_d   = frame_end ? pend_dp_q  : act_dp_q;
    pend_dig_d = load ? digits_in : pend_dig_q;
    pend_dp_d  = load ? dp_in     : pend_dp_q;
  end

  always_comb begin
    cur_val = act_dig_q[{idx_q, 2'b00} +: 4];
    unique case (cur_val)
      4'h0: seg_hi = 7'h3F;
      4'h1: seg_hi = 7'h06;
      4'h2: seg_hi = 7'h5B;
      4'h3: seg_hi = 7'h4F;
      4'h4: seg_hi = 7'h66;
      4'h5: seg_hi = 7'h6D;
      4'h6: seg_hi = 7'h7D;
      4'h7: seg_hi = 7'h07;
      4'h8: seg_hi = 7'h7F;
      4'h9: seg_hi = 7'h6F;
      4'hA: seg_hi = 7'h77;
      4'hB: seg_hi = 7'h7C;
      4'hC: seg_hi = 7'h39;
      4'hD: seg_hi = 7'h5E;
      4'hE: seg_hi = 7'h79;
      default: seg_hi = 7'h71;
    endcase

    // Shifting out the lower digits leaves this digit and everything above it.
    lz_dark = lz_blank_en && (idx_q != '0) && ((act_dig_q >> {idx_q, 2'b00}) == '0);
    dark    = lz_dark || blank_mask[idx_q] || (blink_mask[idx_q] && blink_phase_q);
    lit     = !dark && (pwm_cnt_q <= brightness);

    an_onehot        = '0;
    an_onehot[idx_q] = lit;
    an_d  = an_onehot ^ {NUM_DIGITS{POL}};
    seg_d = (lit ? seg_hi : 7'h00) ^ {7{POL}};
    dp_d  = (lit && act_dp_q[idx_q]) ^ POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      idx_q         <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pend_dig_q    <= '0;
      pend_dp_q     <= '0;
      act_dig_q     <= '0;
      act_dp_q      <= '0;
      an_q          <= {NUM_DIGITS{POL}};
      seg_q         <= {7{POL}};
      dp_q          <= POL;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_dig_q    <= pend_dig_d;
      pend_dp_q     <= pend_dp_d;
      act_dig_q     <= act_dig_d;
      act_dp_q      <= act_dp_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an         = an_q;
  assign sevenseg   = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_end;

endmodule
